// File: rtl/pc88_loader_sink.sv
// Loader byte-handshake sink. Packs even/odd loader bytes into 16-bit words.
// Each word is written through the SDRAM request/acknowledge port before the loader byte is acked.
//
// state    | meaning
// IDLE     | waiting for a loader byte, or for a session end that needs a flush
// FLUSH    | writing a lone pending low byte (be=01)
// MEM_WR   | writing a paired word (be=11) or a lone high byte (be=10)
// ACK      | one-cycle ldr_ack; byte_count/checksum advance
// WAIT_LOW | waiting for the initiator to release ldr_wr
module pc88_loader_sink #(
  parameter int                ADDR_W    = 19,
  parameter int                MEM_AW    = 24,
  parameter logic [MEM_AW-1:0] BASE_WORD = 24'h000000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ldr_oe,
  input  logic              ldr_wr,
  input  logic [ADDR_W-1:0] ldr_adr,
  input  logic [7:0]        ldr_wdat,
  output logic              ldr_ack,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [15:0]       mem_wdat,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  output logic              busy,
  output logic [19:0]       byte_count,
  output logic [7:0]        checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_MEM_WR,
    S_ACK,
    S_WAIT_LOW
  } state_t;

  state_t state_q, state_d;

  logic              pending_q, pending_d;
  logic [7:0]        pend_lo_q, pend_lo_d;
  logic [ADDR_W-2:0] pend_word_q, pend_word_d;

  logic              mem_req_d, ldr_ack_d;
  logic [MEM_AW-1:0] mem_adr_d;
  logic [15:0]       mem_wdat_d;
  logic [1:0]        mem_be_d;
  logic [19:0]       byte_count_d;
  logic [7:0]        checksum_d;

  logic [ADDR_W-2:0] adr_word;
  logic              adr_odd;
  logic              pair_hit;

  assign adr_word = ldr_adr[ADDR_W-1:1];
  assign adr_odd  = ldr_adr[0];
  assign pair_hit = pending_q && (pend_word_q == adr_word);

  // The sum wraps silently at MEM_AW bits.
  function automatic logic [MEM_AW-1:0] word_addr(input logic [ADDR_W-2:0] w);
    return BASE_WORD + MEM_AW'(w);
  endfunction

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      pend_lo_q   <= 8'h00;
      pend_word_q <= '0;
      ldr_ack     <= 1'b0;
      mem_req     <= 1'b0;
      mem_adr     <= '0;
      mem_wdat    <= 16'h0000;
      mem_be      <= 2'b00;
      byte_count  <= 20'h00000;
      checksum    <= 8'h00;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pend_lo_q   <= pend_lo_d;
      pend_word_q <= pend_word_d;
      ldr_ack     <= ldr_ack_d;
      mem_req     <= mem_req_d;
      mem_adr     <= mem_adr_d;
      mem_wdat    <= mem_wdat_d;
      mem_be      <= mem_be_d;
      byte_count  <= byte_count_d;
      checksum    <= checksum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ldr_oe && ldr_wr) begin
          if (!adr_odd && !pending_q)
            state_d = S_ACK;
          else if (adr_odd && (pair_hit || !pending_q))
            state_d = S_MEM_WR;
          else
            state_d = S_FLUSH;   // request stays held and is re-evaluated afterwards
        end else if (!ldr_oe && pending_q) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH:    if (mem_ack) state_d = S_IDLE;
      S_MEM_WR:   if (mem_ack) state_d = S_ACK;
      S_ACK:      state_d = S_WAIT_LOW;
      S_WAIT_LOW: if (!ldr_wr) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_comb begin
    pending_d    = pending_q;
    pend_lo_d    = pend_lo_q;
    pend_word_d  = pend_word_q;
    mem_adr_d    = mem_adr;
    mem_wdat_d   = mem_wdat;
    mem_be_d     = mem_be;
    mem_req_d    = (state_d == S_MEM_WR) || (state_d == S_FLUSH);
    ldr_ack_d    = (state_d == S_ACK);
    byte_count_d = byte_count;
    checksum_d   = checksum;

    if (state_q == S_IDLE) begin
      if (state_d == S_ACK) begin
        pending_d   = 1'b1;
        pend_lo_d   = ldr_wdat;
        pend_word_d = adr_word;
      end else if (state_d == S_MEM_WR) begin
        mem_adr_d  = word_addr(adr_word);
        mem_wdat_d = {ldr_wdat, pending_q ? pend_lo_q : 8'h00};
        mem_be_d   = pending_q ? 2'b11 : 2'b10;
      end else if (state_d == S_FLUSH) begin
        mem_adr_d  = word_addr(pend_word_q);
        mem_wdat_d = {8'h00, pend_lo_q};
        mem_be_d   = 2'b01;
      end
    end

    if ((state_q == S_MEM_WR || state_q == S_FLUSH) && mem_ack)
      pending_d = 1'b0;

    if (state_d == S_ACK) begin
      byte_count_d = byte_count + 20'd1;
      checksum_d   = checksum + ldr_wdat;
    end
  end

  assign busy = (state_q != S_IDLE) || pending_q;

endmodule
